pulse_arbiter: RTL and testbench

Shares one outgoing strobe line among N_REQ requesters that each deliver single-cycle request pulses, typically the edge pulses from the ROC pulse generators. Requests are latched as pending and granted round-robin. Each grant drives a strobe of programmable width, followed by a programmable minimum gap, and the winner's index is reported alongside the strobe. Requests that arrive while the same source is still pending are counted as drops.

---
 rtl/pulse_arb_pkg.sv | 15 +
 rtl/pulse_arbiter_if.sv | 33 +++
 rtl/pulse_arbiter_rr_picker.sv | 32 +++
 rtl/pulse_arbiter.sv | 121 ++++++++++++
 tb/tb_pulse_arbiter.sv | 285 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pulse_arb_pkg.sv
// Shared state encoding and default parameter values for pulse_arbiter.
package pulse_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STROBE = 2'd1,
        GAP    = 2'd2
    } arb_state_t;

    localparam int unsigned N_REQ_DEF  = 4;
    localparam int unsigned ID_W_DEF   = 2;
    localparam int unsigned CNT_W_DEF  = 8;
    localparam int unsigned DROP_W_DEF = 16;

endpackage

// File: rtl/pulse_arbiter_if.sv
// Request/strobe bundle between requesters (master) and pulse_arbiter (slave).
interface pulse_arbiter_if
    import pulse_arb_pkg::*;
#(
    parameter int unsigned N_REQ  = N_REQ_DEF,
    parameter int unsigned ID_W   = ID_W_DEF,
    parameter int unsigned CNT_W  = CNT_W_DEF,
    parameter int unsigned DROP_W = DROP_W_DEF
);

    logic              enable_i;
    logic [N_REQ-1:0]  req_i;
    logic [CNT_W-1:0]  width_i;
    logic [CNT_W-1:0]  gap_i;
    logic              clear_cnt_i;
    logic              strobe_o;
    logic [ID_W-1:0]   strobe_id_o;
    logic              busy_o;
    logic [N_REQ-1:0]  pending_o;
    logic              drop_o;
    logic [DROP_W-1:0] drop_cnt_o;

    modport master (
        output enable_i, req_i, width_i, gap_i, clear_cnt_i,
        input  strobe_o, strobe_id_o, busy_o, pending_o, drop_o, drop_cnt_o
    );

    modport slave (
        input  enable_i, req_i, width_i, gap_i, clear_cnt_i,
        output strobe_o, strobe_id_o, busy_o, pending_o, drop_o, drop_cnt_o
    );

endinterface

// File: rtl/pulse_arbiter_rr_picker.sv
// Combinational round-robin picker: first set pending bit at or after the pointer, with wrap.
module rr_picker
    import pulse_arb_pkg::*;
#(
    parameter int unsigned N_REQ = N_REQ_DEF,
    parameter int unsigned ID_W  = ID_W_DEF
) (
    input  logic [N_REQ-1:0] i_pending,
    input  logic [ID_W-1:0]  i_ptr,
    output logic             o_valid,
    output logic [ID_W-1:0]  o_winner
);

    // Each source's rotated distance from the pointer; the nearest pending source wins.
    always_comb begin
        int unsigned w_dist;
        int unsigned w_best;
        o_valid  = 1'b0;
        o_winner = '0;
        w_best   = N_REQ;
        w_dist   = 0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            w_dist = (i + N_REQ - 32'(i_ptr)) % N_REQ;
            if (i_pending[i] && (w_dist < w_best)) begin
                w_best   = w_dist;
                o_valid  = 1'b1;
                o_winner = ID_W'(i);
            end
        end
    end

endmodule

// File: rtl/pulse_arbiter.sv
// Round-robin arbiter sharing one strobe line among N_REQ pulse requesters.
module pulse_arbiter
    import pulse_arb_pkg::*;
#(
    parameter int unsigned N_REQ  = N_REQ_DEF,
    parameter int unsigned ID_W   = ID_W_DEF,
    parameter int unsigned CNT_W  = CNT_W_DEF,
    parameter int unsigned DROP_W = DROP_W_DEF
) (
    input  logic           clk_i,
    input  logic           resetn_i,
    pulse_arbiter_if.slave arb
);

    arb_state_t        r_state;
    arb_state_t        w_next_state;
    logic [ID_W-1:0]   r_ptr;
    logic [ID_W-1:0]   r_id;
    logic [ID_W-1:0]   w_winner;
    logic [ID_W-1:0]   w_ptr_next;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  w_width_m1;
    logic [N_REQ-1:0]  r_pending;
    logic [N_REQ-1:0]  w_grant_vec;
    logic [N_REQ-1:0]  w_drop_vec;
    logic [DROP_W-1:0] r_drop_cnt;
    logic              r_strobe;
    logic              r_busy;
    logic              r_drop;
    logic              w_valid;
    logic              w_grant;
    logic              w_drop;
    logic              w_strobe_nxt;
    logic              w_busy_nxt;

    rr_picker #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_picker (
        .i_pending (r_pending),
        .i_ptr     (r_ptr),
        .o_valid   (w_valid),
        .o_winner  (w_winner)
    );

    assign w_grant     = (r_state == IDLE) && arb.enable_i && w_valid;
    assign w_grant_vec = w_grant ? (N_REQ'(1) << w_winner) : '0;
    assign w_drop_vec  = arb.req_i & r_pending & ~w_grant_vec;
    assign w_drop      = |w_drop_vec;
    assign w_width_m1  = (arb.width_i == '0) ? '0 : arb.width_i - CNT_W'(1);
    assign w_ptr_next  = (w_winner == ID_W'(N_REQ - 1)) ? '0 : w_winner + ID_W'(1);

    always_ff @(posedge clk_i) begin
        if (!resetn_i) begin
            r_state  <= IDLE;
            r_strobe <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            r_state  <= w_next_state;
            r_strobe <= w_strobe_nxt;
            r_busy   <= w_busy_nxt;
        end
    end

    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            IDLE:    if (w_grant) w_next_state = STROBE;
            STROBE:  if (r_cnt == '0) w_next_state = (arb.gap_i != '0) ? GAP : IDLE;
            GAP:     if (r_cnt == CNT_W'(1)) w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // Strobe and busy are registered copies of the state the FSM is entering.
    always_comb begin
        w_strobe_nxt = (w_next_state == STROBE);
        w_busy_nxt   = (w_next_state != IDLE);
    end

    always_ff @(posedge clk_i) begin
        if (!resetn_i) begin
            r_cnt <= '0;
            r_id  <= '0;
            r_ptr <= '0;
        end else if (w_grant) begin
            r_cnt <= w_width_m1;
            r_id  <= w_winner;
            r_ptr <= w_ptr_next;
        end else if (r_state == STROBE) begin
            r_cnt <= (r_cnt == '0) ? arb.gap_i : r_cnt - CNT_W'(1);
        end else if (r_state == GAP) begin
            r_cnt <= r_cnt - CNT_W'(1);
        end
    end

    // A new request on the grant edge re-sets the bit after the grant clears it.
    always_ff @(posedge clk_i) begin
        if (!resetn_i) begin
            r_pending  <= '0;
            r_drop     <= 1'b0;
            r_drop_cnt <= '0;
        end else begin
            r_pending <= (r_pending & ~w_grant_vec) | arb.req_i;
            r_drop    <= w_drop;
            if (arb.clear_cnt_i) begin
                r_drop_cnt <= '0;
            end else if (w_drop && (r_drop_cnt != '1)) begin
                r_drop_cnt <= r_drop_cnt + DROP_W'(1);
            end
        end
    end

    assign arb.strobe_o    = r_strobe;
    assign arb.strobe_id_o = r_id;
    assign arb.busy_o      = r_busy;
    assign arb.pending_o   = r_pending;
    assign arb.drop_o      = r_drop;
    assign arb.drop_cnt_o  = r_drop_cnt;

endmodule

// File: tb/tb_pulse_arbiter.sv
// Self-checking bench for pulse_arbiter: vector table, corner sequences, randomized run against a model.
module tb_pulse_arbiter;

    localparam int N  = 4;
    localparam int IW = 2;
    localparam int CW = 8;
    localparam int DW = 8;

    logic clk;
    logic rstn;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    pulse_arbiter_if #(.N_REQ(N), .ID_W(IW), .CNT_W(CW), .DROP_W(DW)) arb ();

    pulse_arbiter #(.N_REQ(N), .ID_W(IW), .CNT_W(CW), .DROP_W(DW)) dut (
        .clk_i    (clk),
        .resetn_i (rstn),
        .arb      (arb.slave)
    );

    int checks = 0;
    int errors = 0;
    bit model_on = 1'b0;

    // Reference model: remaining strobe-high cycles and remaining gap cycles.
    logic [N-1:0] m_pend;
    int m_ptr, m_hi, m_lo, m_id, m_cnt;
    bit m_drop;

    typedef struct {
        bit           rst;
        logic [N-1:0] req;
        int           w;
        int           g;
        logic [N-1:0] pend;
        bit           strobe;
        bit           busy;
        int           id;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(bit rst, logic [N-1:0] req, int w, int g,
                                logic [N-1:0] pend, bit s, bit b, int id);
        vec_t v;
        v.rst = rst; v.req = req; v.w = w; v.g = g;
        v.pend = pend; v.strobe = s; v.busy = b; v.id = id;
        tbl.push_back(v);
    endfunction

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    task automatic model_step();
        int win;
        bit dropped;
        win = -1;
        dropped = 1'b0;
        if (!rstn) begin
            m_pend = '0; m_ptr = 0; m_hi = 0; m_lo = 0; m_id = 0; m_cnt = 0; m_drop = 1'b0;
            return;
        end
        if (m_hi == 0 && m_lo == 0 && arb.enable_i) begin
            for (int k = 0; k < N; k++) begin
                int s;
                s = (m_ptr + k) % N;
                if (win < 0 && m_pend[s]) win = s;
            end
        end
        for (int i = 0; i < N; i++)
            if (arb.req_i[i] && m_pend[i] && i != win) dropped = 1'b1;
        for (int i = 0; i < N; i++) begin
            if (i == win) m_pend[i] = 1'b0;
            if (arb.req_i[i]) m_pend[i] = 1'b1;
        end
        m_drop = dropped;
        if (arb.clear_cnt_i) m_cnt = 0;
        else if (dropped && m_cnt < (1 << DW) - 1) m_cnt++;
        if (win >= 0) begin
            m_id  = win;
            m_ptr = (win + 1) % N;
            m_hi  = (arb.width_i == 0) ? 1 : int'(arb.width_i);
        end else if (m_hi > 0) begin
            m_hi--;
            if (m_hi == 0) m_lo = int'(arb.gap_i);
        end else if (m_lo > 0) begin
            m_lo--;
        end
    endtask

    task automatic model_check();
        check("rnd_strobe",  arb.strobe_o,    int'(m_hi > 0));
        check("rnd_busy",    arb.busy_o,      int'(m_hi > 0 || m_lo > 0));
        check("rnd_id",      arb.strobe_id_o, m_id);
        check("rnd_pending", arb.pending_o,   m_pend);
        check("rnd_drop",    arb.drop_o,      m_drop);
        check("rnd_dropcnt", arb.drop_cnt_o,  m_cnt);
    endtask

    task automatic cyc();
        @(posedge clk);
        if (model_on) model_step();
        @(negedge clk);
        if (model_on) model_check();
    endtask

    task automatic reset_dut();
        rstn = 1'b0;
        arb.req_i = '0;
        arb.clear_cnt_i = 1'b0;
        cyc();
        rstn = 1'b1;
    endtask

    initial begin
        int fair_exp[5] = '{0, 1, 2, 3, 0};
        int got_ids[$];
        logic [N-1:0] nreq;
        int rising, highs;
        bit prev;

        rstn = 1'b0;
        arb.enable_i = 1'b0; arb.req_i = '0; arb.width_i = 8'd1;
        arb.gap_i = '0; arb.clear_cnt_i = 1'b0;
        repeat (2) cyc();
        check("rst_strobe",  arb.strobe_o,    0);
        check("rst_id",      arb.strobe_id_o, 0);
        check("rst_busy",    arb.busy_o,      0);
        check("rst_pending", arb.pending_o,   0);
        check("rst_drop",    arb.drop_o,      0);
        check("rst_dropcnt", arb.drop_cnt_o,  0);
        rstn = 1'b1;

        // Vector table: single request, simultaneous requests, zero width.
        add(0, 4'b0010, 3, 0, 4'b0010, 0, 0, 0);
        add(0, 4'b0000, 3, 0, 4'b0000, 1, 1, 1);
        add(0, 4'b0000, 3, 0, 4'b0000, 1, 1, 1);
        add(0, 4'b0000, 3, 0, 4'b0000, 1, 1, 1);
        add(0, 4'b0000, 3, 0, 4'b0000, 0, 0, 1);
        add(0, 4'b0000, 3, 0, 4'b0000, 0, 0, 1);
        add(1, 4'b0000, 1, 2, 4'b0000, 0, 0, 0);
        add(0, 4'b1011, 1, 2, 4'b1011, 0, 0, 0);
        add(0, 4'b0000, 1, 2, 4'b1010, 1, 1, 0);
        add(0, 4'b0000, 1, 2, 4'b1010, 0, 1, 0);
        add(0, 4'b0000, 1, 2, 4'b1010, 0, 1, 0);
        add(0, 4'b0000, 1, 2, 4'b1010, 0, 0, 0);
        add(0, 4'b0000, 1, 2, 4'b1000, 1, 1, 1);
        add(0, 4'b0000, 1, 2, 4'b1000, 0, 1, 1);
        add(0, 4'b0000, 1, 2, 4'b1000, 0, 1, 1);
        add(0, 4'b0000, 1, 2, 4'b1000, 0, 0, 1);
        add(0, 4'b0000, 1, 2, 4'b0000, 1, 1, 3);
        add(0, 4'b0000, 1, 2, 4'b0000, 0, 1, 3);
        add(0, 4'b0000, 1, 2, 4'b0000, 0, 1, 3);
        add(0, 4'b0000, 1, 2, 4'b0000, 0, 0, 3);
        add(1, 4'b0000, 0, 0, 4'b0000, 0, 0, 0);
        add(0, 4'b0001, 0, 0, 4'b0001, 0, 0, 0);
        add(0, 4'b0000, 0, 0, 4'b0000, 1, 1, 0);
        add(0, 4'b0000, 0, 0, 4'b0000, 0, 0, 0);

        arb.enable_i = 1'b1;
        foreach (tbl[r]) begin
            rstn = !tbl[r].rst;
            arb.req_i = tbl[r].req;
            arb.width_i = CW'(tbl[r].w);
            arb.gap_i = CW'(tbl[r].g);
            cyc();
            check($sformatf("tbl%0d_strobe", r),  arb.strobe_o,    tbl[r].strobe);
            check($sformatf("tbl%0d_busy", r),    arb.busy_o,      tbl[r].busy);
            check($sformatf("tbl%0d_id", r),      arb.strobe_id_o, tbl[r].id);
            check($sformatf("tbl%0d_pending", r), arb.pending_o,   tbl[r].pend);
            check($sformatf("tbl%0d_drop", r),    arb.drop_o,      0);
        end
        rstn = 1'b1;

        // Fairness: source 0 re-requests after each of its grants.
        reset_dut();
        arb.enable_i = 1'b1; arb.width_i = 8'd1; arb.gap_i = 8'd0;
        arb.req_i = 4'b1111;
        cyc();
        nreq = '0;
        for (int c = 0; c < 40 && got_ids.size() < 5; c++) begin
            arb.req_i = nreq;
            cyc();
            nreq = '0;
            if (arb.strobe_o) begin
                got_ids.push_back(int'(arb.strobe_id_o));
                if (arb.strobe_id_o == 0) nreq = 4'b0001;
            end
        end
        arb.req_i = '0;
        check("fair_count", got_ids.size(), 5);
        for (int k = 0; k < 5; k++)
            check($sformatf("fair_order%0d", k), (k < got_ids.size()) ? got_ids[k] : -1, fair_exp[k]);
        check("fair_dropcnt", arb.drop_cnt_o, 0);

        // Drops with enable low, saturation, clear beating increment.
        reset_dut();
        arb.enable_i = 1'b0;
        arb.req_i = 4'b0100; cyc();
        arb.req_i = 4'b0000; cyc();
        check("drop_none_yet", arb.drop_o, 0);
        arb.req_i = 4'b0100; cyc();
        check("drop_pulse", arb.drop_o, 1);
        check("drop_cnt1", arb.drop_cnt_o, 1);
        arb.req_i = 4'b0000; cyc();
        check("drop_pulse_end", arb.drop_o, 0);
        check("drop_cnt_hold", arb.drop_cnt_o, 1);
        check("drop_pending", arb.pending_o, 4'b0100);
        arb.req_i = 4'b0100;
        repeat (300) cyc();
        check("drop_sat", arb.drop_cnt_o, (1 << DW) - 1);
        repeat (5) cyc();
        check("drop_sat_hold", arb.drop_cnt_o, (1 << DW) - 1);
        arb.clear_cnt_i = 1'b1; cyc();
        check("drop_clear", arb.drop_cnt_o, 0);
        check("drop_clear_pulse", arb.drop_o, 1);
        arb.clear_cnt_i = 1'b0; arb.req_i = '0;

        // Set wins: new request for source 0 on its own grant edge.
        reset_dut();
        arb.enable_i = 1'b1; arb.width_i = 8'd2; arb.gap_i = 8'd0;
        arb.req_i = 4'b0001; cyc();
        arb.req_i = 4'b0001; cyc();
        check("setwin_pending", arb.pending_o, 4'b0001);
        check("setwin_strobe", arb.strobe_o, 1);
        check("setwin_drop", arb.drop_o, 0);
        arb.req_i = '0;
        prev = 1'b1; rising = 0;
        repeat (8) begin
            cyc();
            if (arb.strobe_o && !prev) rising++;
            prev = arb.strobe_o;
        end
        check("setwin_second_strobe", rising, 1);
        check("setwin_dropcnt", arb.drop_cnt_o, 0);
        check("setwin_pending_end", arb.pending_o, 0);

        // Reset in the middle of a width-5 strobe.
        reset_dut();
        arb.enable_i = 1'b1; arb.width_i = 8'd5; arb.gap_i = 8'd0;
        arb.req_i = 4'b0010; cyc();
        arb.req_i = 4'b0000; cyc();
        cyc();
        check("midrst_pre_strobe", arb.strobe_o, 1);
        rstn = 1'b0; cyc();
        check("midrst_strobe", arb.strobe_o, 0);
        check("midrst_busy", arb.busy_o, 0);
        check("midrst_id", arb.strobe_id_o, 0);
        check("midrst_pending", arb.pending_o, 0);
        rstn = 1'b1;
        highs = 0;
        repeat (10) begin
            cyc();
            if (arb.strobe_o || arb.busy_o) highs++;
        end
        check("midrst_quiet", highs, 0);

        // Randomized run against the reference model.
        model_on = 1'b1;
        reset_dut();
        for (int c = 0; c < 2000; c++) begin
            logic [N-1:0] r;
            for (int i = 0; i < N; i++) r[i] = ($urandom_range(0, 5) == 0);
            arb.req_i = r;
            arb.enable_i = ($urandom_range(0, 7) != 0);
            arb.width_i = CW'($urandom_range(0, 4));
            arb.gap_i = CW'($urandom_range(0, 3));
            arb.clear_cnt_i = ($urandom_range(0, 49) == 0);
            rstn = ($urandom_range(0, 299) != 0);
            cyc();
        end
        model_on = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
